// File: rtl/idu_mt.sv
// Multi-thread RV32I decode stage: combinational decoder feeding a 2-entry
// thread-tagged in-order output buffer with per-thread flush.
module idu_mt #(
  parameter  int XLEN    = 32,
  parameter  int THREADS = 4,
  localparam int TID_W   = $clog2(THREADS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_inst_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [TID_W-1:0] in_tid_i,
  input  logic             flush_i,
  input  logic [TID_W-1:0] flush_tid_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TID_W-1:0] out_tid_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic             out_rs1_en_o,
  output logic             out_rs2_en_o,
  output logic             out_rd_en_o,
  output logic [4:0]       out_rs1_o,
  output logic [4:0]       out_rs2_o,
  output logic [4:0]       out_rd_o,
  output logic [3:0]       out_class_o,
  output logic [2:0]       out_fn3_o,
  output logic             out_sub_o,
  output logic             out_sra_o,
  output logic             out_imm_src_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic             out_illegal_o
);

  typedef enum logic [3:0] {
    CL_ALU   = 4'd0,
    CL_BR    = 4'd1,
    CL_JAL   = 4'd2,
    CL_JALR  = 4'd3,
    CL_LUI   = 4'd4,
    CL_AUIPC = 4'd5,
    CL_LOAD  = 4'd6,
    CL_STORE = 4'd7,
    CL_FENCE = 4'd8,
    CL_SYS   = 4'd9
  } uop_class_e;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [XLEN-1:0]  pc;
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_en;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    uop_class_e       cls;
    logic [2:0]       fn3;
    logic             sub;
    logic             sra;
    logic             imm_src;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } uop_t;

  logic [6:0]  opc;
  logic [2:0]  fn3;
  logic [6:0]  fn7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [31:0] imm32;
  uop_t        dec;

  assign opc    = in_inst_i[6:0];
  assign fn3    = in_inst_i[14:12];
  assign fn7    = in_inst_i[31:25];
  assign imm_i  = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
  assign imm_s  = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
  assign imm_b  = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7], in_inst_i[30:25],
                   in_inst_i[11:8], 1'b0};
  assign imm_u  = {in_inst_i[31:12], 12'b0};
  assign imm_j  = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12], in_inst_i[20],
                   in_inst_i[30:21], 1'b0};
  assign imm_sh = {27'b0, in_inst_i[24:20]};

  // Combinational decode of the offered instruction into a uop.
  always_comb begin
    dec         = '0;
    imm32       = '0;
    dec.tid     = in_tid_i;
    dec.pc      = in_pc_i;
    dec.rs1     = in_inst_i[19:15];
    dec.rs2     = in_inst_i[24:20];
    dec.rd      = in_inst_i[11:7];
    dec.fn3     = fn3;
    dec.cls     = CL_ALU;
    unique case (opc)
      7'b0110011: begin // OP
        dec.rs1_en  = 1'b1;
        dec.rs2_en  = 1'b1;
        dec.rd_en   = 1'b1;
        dec.sub     = (fn3 == 3'b000 && fn7[5]) || fn3 == 3'b010 || fn3 == 3'b011;
        dec.sra     = (fn3 == 3'b101) && fn7[5];
        dec.illegal = !(fn7 == 7'b0000000 ||
                        (fn7 == 7'b0100000 && (fn3 == 3'b000 || fn3 == 3'b101)));
      end
      7'b0010011: begin // OP-IMM
        dec.rs1_en  = 1'b1;
        dec.rd_en   = 1'b1;
        dec.imm_src = 1'b1;
        dec.sub     = (fn3 == 3'b010) || (fn3 == 3'b011);
        if (fn3 == 3'b001 || fn3 == 3'b101) begin
          imm32       = imm_sh;
          dec.sra     = (fn3 == 3'b101) && fn7[5];
          dec.illegal = (fn3 == 3'b001) ? (fn7 != 7'b0000000)
                                        : !(fn7 == 7'b0000000 || fn7 == 7'b0100000);
        end else begin
          imm32 = imm_i;
        end
      end
      7'b0110111: begin // LUI
        dec.cls     = CL_LUI;
        dec.rd_en   = 1'b1;
        dec.imm_src = 1'b1;
        imm32       = imm_u;
      end
      7'b0010111: begin // AUIPC
        dec.cls     = CL_AUIPC;
        dec.rd_en   = 1'b1;
        dec.imm_src = 1'b1;
        imm32       = imm_u;
      end
      7'b1101111: begin // JAL
        dec.cls     = CL_JAL;
        dec.rd_en   = 1'b1;
        dec.imm_src = 1'b1;
        imm32       = imm_j;
      end
      7'b1100111: begin // JALR
        dec.cls     = CL_JALR;
        dec.rs1_en  = 1'b1;
        dec.rd_en   = 1'b1;
        dec.imm_src = 1'b1;
        imm32       = imm_i;
      end
      7'b1100011: begin // BRANCH
        dec.cls     = CL_BR;
        dec.rs1_en  = 1'b1;
        dec.rs2_en  = 1'b1;
        dec.sub     = 1'b1;
        imm32       = imm_b;
        dec.illegal = (fn3 == 3'b010) || (fn3 == 3'b011);
      end
      7'b0000011: begin // LOAD
        dec.cls     = CL_LOAD;
        dec.rs1_en  = 1'b1;
        dec.rd_en   = 1'b1;
        dec.imm_src = 1'b1;
        imm32       = imm_i;
        dec.illegal = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
      end
      7'b0100011: begin // STORE
        dec.cls     = CL_STORE;
        dec.rs1_en  = 1'b1;
        dec.rs2_en  = 1'b1;
        dec.imm_src = 1'b1;
        imm32       = imm_s;
        dec.illegal = (fn3 >= 3'b011);
      end
      7'b0001111: begin // MISC-MEM
        dec.cls = CL_FENCE;
        imm32   = imm_i;
      end
      7'b1110011: begin // SYSTEM
        dec.cls     = CL_SYS;
        imm32       = imm_i;
        dec.rd_en   = (fn3 != 3'b000);
        dec.rs1_en  = (fn3 != 3'b000) && !fn3[2];
        dec.imm_src = fn3[2];
        if (fn3 == 3'b000)
          dec.illegal = !(in_inst_i[31:7] == 25'h0000000 || in_inst_i[31:7] == 25'h0002000);
        else
          dec.illegal = (fn3 == 3'b100);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (dec.illegal) begin
      dec.rs1_en = 1'b0;
      dec.rs2_en = 1'b0;
      dec.rd_en  = 1'b0;
    end
    if (dec.rd == 5'd0) dec.rd_en = 1'b0;
  end

  uop_t e0_q, e0_d, e1_q, e1_d;
  logic v0_q, v0_d, v1_q, v1_d;
  logic pop, push, kill0, kill1, keep0, keep1;

  assign in_ready_o = !(v0_q && v1_q);
  assign pop        = v0_q && out_ready_i;
  assign push       = in_valid_i && in_ready_o && !(flush_i && in_tid_i == flush_tid_i);
  assign kill0      = flush_i && (e0_q.tid == flush_tid_i);
  assign kill1      = flush_i && (e1_q.tid == flush_tid_i);
  assign keep0      = v0_q && !pop && !kill0;
  assign keep1      = v1_q && !kill1;

  // Buffer next state: drop popped/flushed entries, compact survivors to the head, then append.
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = 1'b0;
    v1_d = 1'b0;
    if (keep0) begin
      v0_d = 1'b1;
      if (keep1) begin
        v1_d = 1'b1;
      end else if (push) begin
        v1_d = 1'b1;
        e1_d = dec;
      end
    end else if (keep1) begin
      v0_d = 1'b1;
      e0_d = e1_q;
      if (push) begin
        v1_d = 1'b1;
        e1_d = dec;
      end
    end else if (push) begin
      v0_d = 1'b1;
      e0_d = dec;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

  assign out_valid_o   = v0_q;
  assign out_tid_o     = e0_q.tid;
  assign out_pc_o      = e0_q.pc;
  assign out_rs1_en_o  = e0_q.rs1_en;
  assign out_rs2_en_o  = e0_q.rs2_en;
  assign out_rd_en_o   = e0_q.rd_en;
  assign out_rs1_o     = e0_q.rs1;
  assign out_rs2_o     = e0_q.rs2;
  assign out_rd_o      = e0_q.rd;
  assign out_class_o   = e0_q.cls;
  assign out_fn3_o     = e0_q.fn3;
  assign out_sub_o     = e0_q.sub;
  assign out_sra_o     = e0_q.sra;
  assign out_imm_src_o = e0_q.imm_src;
  assign out_imm_o     = e0_q.imm;
  assign out_illegal_o = e0_q.illegal;

endmodule

// File: tb/tb_idu_mt.sv
// Directed bench for idu_mt: decode vectors, buffer back-pressure, flush, async reset.
module tb_idu_mt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_inst_i, in_pc_i;
  logic [1:0]  in_tid_i;
  logic        flush_i;
  logic [1:0]  flush_tid_i;
  logic        out_valid_o, out_ready_i;
  logic [1:0]  out_tid_o;
  logic [31:0] out_pc_o;
  logic        out_rs1_en_o, out_rs2_en_o, out_rd_en_o;
  logic [4:0]  out_rs1_o, out_rs2_o, out_rd_o;
  logic [3:0]  out_class_o;
  logic [2:0]  out_fn3_o;
  logic        out_sub_o, out_sra_o, out_imm_src_o;
  logic [31:0] out_imm_o;
  logic        out_illegal_o;

  int n_cmp = 0;
  int n_err = 0;

  idu_mt #(.XLEN(32), .THREADS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_inst_i(in_inst_i),
    .in_pc_i(in_pc_i), .in_tid_i(in_tid_i),
    .flush_i(flush_i), .flush_tid_i(flush_tid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tid_o(out_tid_o),
    .out_pc_o(out_pc_o), .out_rs1_en_o(out_rs1_en_o), .out_rs2_en_o(out_rs2_en_o),
    .out_rd_en_o(out_rd_en_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
    .out_rd_o(out_rd_o), .out_class_o(out_class_o), .out_fn3_o(out_fn3_o),
    .out_sub_o(out_sub_o), .out_sra_o(out_sra_o), .out_imm_src_o(out_imm_src_o),
    .out_imm_o(out_imm_o), .out_illegal_o(out_illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and hold it until accepted (bounded wait).
  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic [1:0] tid);
    int unsigned n;
    n          = 0;
    in_inst_i  = inst;
    in_pc_i    = pc;
    in_tid_i   = tid;
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) chk("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid_i = 1'b0; in_inst_i = '0; in_pc_i = '0; in_tid_i = '0;
    flush_i = 1'b0; flush_tid_i = '0; out_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_imm", out_imm_o, 0);
    chk("rst_class", out_class_o, 0);
    chk("rst_pc", out_pc_o, 0);
    rst = 1'b1;
    step();
    chk("rst_ready", in_ready_o, 1);

    // Decode vectors, one in flight at a time (each push pops the previous head)
    out_ready_i = 1'b1;
    push(32'hFFF00093, 32'h100, 2'd2); // ADDI x1,x0,-1
    chk("addi_valid", out_valid_o, 1);
    chk("addi_class", out_class_o, 0);
    chk("addi_rd", out_rd_o, 1);
    chk("addi_rd_en", out_rd_en_o, 1);
    chk("addi_imm", out_imm_o, 32'hFFFFFFFF);
    chk("addi_tid", out_tid_o, 2);
    chk("addi_pc", out_pc_o, 32'h100);
    chk("addi_imm_src", out_imm_src_o, 1);

    push(32'hFE000EE3, 32'h104, 2'd0); // BEQ x0,x0,-4
    chk("beq_class", out_class_o, 1);
    chk("beq_sub", out_sub_o, 1);
    chk("beq_rs1_en", out_rs1_en_o, 1);
    chk("beq_rs2_en", out_rs2_en_o, 1);
    chk("beq_rd_en", out_rd_en_o, 0);
    chk("beq_imm", out_imm_o, 32'hFFFFFFFC);

    push(32'h123452B7, 32'h108, 2'd1); // LUI x5,0x12345
    chk("lui_class", out_class_o, 4);
    chk("lui_rd", out_rd_o, 5);
    chk("lui_imm", out_imm_o, 32'h12345000);

    push(32'h00100013, 32'h10C, 2'd1); // ADDI x0,x0,1
    chk("addi0_rd_en", out_rd_en_o, 0);
    chk("addi0_imm", out_imm_o, 1);

    push(32'h00000000, 32'h110, 2'd1);
    chk("zero_illegal", out_illegal_o, 1);
    chk("zero_valid", out_valid_o, 1);

    push(32'h402081B3, 32'h114, 2'd3); // SUB x3,x1,x2
    chk("sub_sub", out_sub_o, 1);
    chk("sub_rs2", out_rs2_o, 2);
    chk("sub_rd", out_rd_o, 3);
    chk("sub_imm_src", out_imm_src_o, 0);
    chk("sub_illegal", out_illegal_o, 0);

    push(32'h4030D093, 32'h118, 2'd3); // SRAI x1,x1,3
    chk("srai_sra", out_sra_o, 1);
    chk("srai_imm", out_imm_o, 3);

    push(32'h40309093, 32'h11C, 2'd3); // SLLI with funct7 0100000
    chk("slli_bad_illegal", out_illegal_o, 1);
    chk("slli_bad_rd_en", out_rd_en_o, 0);

    push(32'h0020A423, 32'h120, 2'd3); // SW x2,8(x1)
    chk("sw_class", out_class_o, 7);
    chk("sw_imm", out_imm_o, 8);
    chk("sw_rs2_en", out_rs2_en_o, 1);
    chk("sw_fn3", out_fn3_o, 2);

    step();
    chk("drain_valid", out_valid_o, 0);

    // Back-pressure: three pushes with out_ready low
    out_ready_i = 1'b0;
    push(32'h00100093, 32'hA00, 2'd0);
    chk("bp_ready_1", in_ready_o, 1);
    push(32'h00200093, 32'hB00, 2'd1);
    chk("bp_ready_2", in_ready_o, 0);
    in_inst_i = 32'h00300093; in_pc_i = 32'hC00; in_tid_i = 2'd2; in_valid_i = 1'b1;
    step();
    step();
    chk("bp_hold_pc", out_pc_o, 32'hA00);
    chk("bp_hold_ready", in_ready_o, 0);
    out_ready_i = 1'b1;
    step();
    chk("bp_order_b", out_pc_o, 32'hB00);
    step();
    in_valid_i = 1'b0;
    chk("bp_order_c", out_pc_o, 32'hC00);
    chk("bp_order_c_tid", out_tid_o, 2);
    step();
    chk("bp_empty", out_valid_o, 0);

    // Flush with compaction
    out_ready_i = 1'b0;
    push(32'h00100093, 32'h200, 2'd1);
    push(32'h00100093, 32'h300, 2'd3);
    flush_i = 1'b1; flush_tid_i = 2'd1;
    step();
    flush_i = 1'b0;
    chk("fl_head_tid", out_tid_o, 3);
    chk("fl_head_pc", out_pc_o, 32'h300);
    chk("fl_count1", in_ready_o, 1);

    // Incoming instruction of the flushed thread is dropped
    in_inst_i = 32'h00100093; in_pc_i = 32'h400; in_tid_i = 2'd2; in_valid_i = 1'b1;
    flush_i = 1'b1; flush_tid_i = 2'd2;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("fl_drop_ready", in_ready_o, 1);
    chk("fl_drop_head", out_pc_o, 32'h300);
    push(32'h00100093, 32'h500, 2'd0);
    chk("fl_full", in_ready_o, 0);

    flush_i = 1'b1; flush_tid_i = 2'd3;
    step();
    flush_i = 1'b0;
    chk("fl_head2_pc", out_pc_o, 32'h500);
    chk("fl_head2_ready", in_ready_o, 1);

    // Pop and flush of the same head in one cycle
    out_ready_i = 1'b1; flush_i = 1'b1; flush_tid_i = 2'd0;
    step();
    flush_i = 1'b0; out_ready_i = 1'b0;
    chk("fl_pop_empty", out_valid_o, 0);

    flush_i = 1'b1; flush_tid_i = 2'd1;
    step();
    flush_i = 1'b0;
    chk("fl_empty_valid", out_valid_o, 0);
    chk("fl_empty_ready", in_ready_o, 1);

    // Asynchronous reset with two uops buffered
    push(32'hFFF00093, 32'h600, 2'd1);
    push(32'hFFF00093, 32'h700, 2'd2);
    chk("ar_pre_valid", out_valid_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_pc", out_pc_o, 0);
    chk("ar_imm", out_imm_o, 0);
    chk("ar_tid", out_tid_o, 0);
    chk("ar_rd_en", out_rd_en_o, 0);
    step();
    rst = 1'b1;
    step();
    chk("ar_post_valid", out_valid_o, 0);
    chk("ar_post_ready", in_ready_o, 1);

    push(32'h00000073, 32'h800, 2'd3); // ECALL
    chk("ecall_class", out_class_o, 9);
    chk("ecall_illegal", out_illegal_o, 0);
    chk("ecall_tid", out_tid_o, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
